// File: rtl/sample_dma_burst_requester.sv
// Walks the active-sample list and issues 4 KB-clipped DMA read bursts, keeping up to MAX_OUTSTANDING in flight.
// Optional statistics counters (req_count/skip_count) are built only with SAMPLE_DMA_REQ_STATS_EN defined.
module sample_dma_burst_requester #(
  parameter int ADDR_W          = 32,
  parameter int ID_W            = 6,
  parameter int LEN_W           = 8,
  parameter int MAX_BURST       = 64,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] sample_addr,
  input  logic [ID_W-1:0]   sample_id,
  input  logic [23:0]       sample_remaining,
  input  logic              sample_valid,
  input  logic              sample_last,
  output logic              load_next_sample,
  output logic [ADDR_W-1:0] dma_req_addr,
  output logic [ID_W-1:0]   dma_req_id,
  output logic [LEN_W-1:0]  dma_req_len,
  output logic              dma_req_valid,
  input  logic              dma_req_ready,
  input  logic              dma_req_done,
  input  logic              all_samples_received,
  output logic              last_request_sent,
  output logic [ID_W-1:0]   last_request_id,
  output logic              all_samples_invalid,
  output logic [15:0]       req_count,
  output logic [15:0]       skip_count
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OUT_W-1:0] MAX_OUT_L = OUT_W'(MAX_OUTSTANDING);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ_NEXT,
    S_WAIT_INFO,
    S_ANALYZE,
    S_SEND,
    S_DRAIN,
    S_WAIT_ALL_DATA
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;
  logic [ID_W-1:0]     last_id_q, last_id_d;
  logic [OUT_W-1:0]    outst_q, outst_d;
  logic                issued_q, issued_d;

  logic                accept;
  logic                out_dec;
  logic                clr_stats;
  logic                inc_req;
  logic                inc_skip;
  logic [12:0]         bound_beats;
  logic [23:0]         len_calc;

  // Beats left before the 4 KB page ends; the address is word aligned.
  always_comb begin
    bound_beats = 13'd1024 - {3'b0, sample_addr[11:2]};
    len_calc    = sample_remaining;
    if (len_calc > 24'(MAX_BURST)) len_calc = 24'(MAX_BURST);
    if (len_calc > {11'b0, bound_beats}) len_calc = {11'b0, bound_beats};
  end

  always_comb begin
    state_d             = state_q;
    addr_d              = addr_q;
    id_d                = id_q;
    len_d               = len_q;
    valid_d             = valid_q;
    last_d              = last_q;
    last_id_d           = last_id_q;
    issued_d            = issued_q;
    outst_d             = outst_q;
    load_next_sample    = 1'b0;
    last_request_sent   = 1'b0;
    all_samples_invalid = 1'b0;
    clr_stats           = 1'b0;
    inc_req             = 1'b0;
    inc_skip            = 1'b0;

    accept  = valid_q && dma_req_ready;
    out_dec = dma_req_done && (outst_q != '0);

    if (accept && !out_dec)      outst_d = outst_q + OUT_W'(1);
    else if (!accept && out_dec) outst_d = outst_q - OUT_W'(1);

    // A handshake completes even if stop arrives in the same cycle.
    if (accept) begin
      issued_d          = 1'b1;
      last_id_d         = id_q;
      inc_req           = 1'b1;
      last_request_sent = last_q;
    end

    if (stop && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && sample_valid && (outst_q == '0)) begin
            state_d   = S_ANALYZE;
            clr_stats = 1'b1;
            issued_d  = 1'b0;
          end
        end
        S_REQ_NEXT: begin
          load_next_sample = 1'b1;
          state_d          = S_WAIT_INFO;
        end
        S_WAIT_INFO: begin
          if (sample_valid) state_d = S_ANALYZE;
        end
        S_ANALYZE: begin
          if (sample_remaining == 24'd0) begin
            inc_skip = 1'b1;
            if (sample_last) begin
              last_request_sent = 1'b1;
              state_d           = S_DRAIN;
            end else begin
              state_d = S_REQ_NEXT;
            end
          end else begin
            addr_d = sample_addr;
            id_d   = sample_id;
            len_d  = len_calc[LEN_W-1:0];
            last_d = sample_last;
            if (outst_q < MAX_OUT_L) begin
              state_d = S_SEND;
              valid_d = 1'b1;
            end
          end
        end
        S_SEND: begin
          if (accept) begin
            valid_d = 1'b0;
            state_d = last_q ? S_DRAIN : S_REQ_NEXT;
          end
        end
        S_DRAIN: begin
          if (outst_q == '0) begin
            if (!issued_q) begin
              all_samples_invalid = 1'b1;
              state_d             = S_IDLE;
            end else begin
              state_d = S_WAIT_ALL_DATA;
            end
          end
        end
        S_WAIT_ALL_DATA: begin
          if (all_samples_received) begin
            state_d  = S_REQ_NEXT;
            issued_d = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      id_q      <= '0;
      len_q     <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      last_id_q <= '0;
      outst_q   <= '0;
      issued_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      id_q      <= id_d;
      len_q     <= len_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      last_id_q <= last_id_d;
      outst_q   <= outst_d;
      issued_q  <= issued_d;
    end
  end

  assign dma_req_addr    = addr_q;
  assign dma_req_id      = id_q;
  assign dma_req_len     = len_q;
  assign dma_req_valid   = valid_q;
  assign last_request_id = last_id_q;

`ifdef SAMPLE_DMA_REQ_STATS_EN
  logic [15:0] req_count_q, req_count_d;
  logic [15:0] skip_count_q, skip_count_d;

  always_comb begin
    req_count_d  = req_count_q;
    skip_count_d = skip_count_q;
    if (clr_stats) begin
      req_count_d  = '0;
      skip_count_d = '0;
    end else begin
      if (inc_req)  req_count_d  = req_count_q + 16'd1;
      if (inc_skip) skip_count_d = skip_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_count_q  <= '0;
      skip_count_q <= '0;
    end else begin
      req_count_q  <= req_count_d;
      skip_count_q <= skip_count_d;
    end
  end

  assign req_count  = req_count_q;
  assign skip_count = skip_count_q;
`else
  logic unused_stats;
  assign unused_stats = ^{clr_stats, inc_req, inc_skip};
  assign req_count    = '0;
  assign skip_count   = '0;
`endif

endmodule

// File: doc/sample_dma_burst_requester.md
# sample_dma_burst_requester

Parametrised successor of the sampler's DMA read requester. Walks the active-sample list served by the information fetcher, computes a per-sample burst length from remaining sample count, clipped to the 4 KB AXI boundary, and issues read requests to the AXI bridge. Requests use a valid/ready handshake, and up to MAX_OUTSTANDING requests may be in flight. Sits between the sample information fetcher and the AXI bridge; it signals the data receiver when the last request of a pass has been accepted.

## Interface
- ADDR_W, 32, request address width (byte address)
- ID_W, 6, sample/request ID width
- LEN_W, 8, burst length field width (beats, 32-bit samples)
- MAX_BURST, 64, maximum beats per request; must satisfy 1 ≤ MAX_BURST ≤ 2^LEN_W − 1
- MAX_OUTSTANDING, 4, maximum accepted-but-not-done requests; ≥ 1
- clk  in  1  sole clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  level; enable fetch passes
- stop  in  1  level; abort to IDLE
- sample_addr  in  ADDR_W  next sample word address, 4-byte aligned
- sample_id  in  ID_W  sample ID
- sample_remaining  in  24  samples left in the voice; 0 means overflowed/finished
- sample_valid  in  1  info fields valid
- sample_last  in  1  this is the last active entry of the list
- load_next_sample  out  1  one-cycle pulse: fetcher advances
- dma_req_addr  out  ADDR_W  registered request address
- dma_req_id  out  ID_W  registered request ID
- dma_req_len  out  LEN_W  registered beat count
- dma_req_valid  out  1  request valid
- dma_req_ready  in  1  bridge accepts
- dma_req_done  in  1  one-cycle pulse per completed request
- all_samples_received  in  1  receiver has all data of the pass
- last_request_sent  out  1  one-cycle pulse on acceptance of last request, or on skip of the last entry
- last_request_id  out  ID_W  ID of the last accepted request in the pass
- all_samples_invalid  out  1  pass issued zero requests
- req_count  out  16  accepted-request counter (see Configuration)
- skip_count  out  16  skipped-entry counter (see Configuration)

## Operation
- States: IDLE, REQ_NEXT, WAIT_INFO, ANALYZE, SEND, DRAIN, WAIT_ALL_DATA.
- IDLE → ANALYZE when start & ~stop & sample_valid.
- REQ_NEXT: assert load_next_sample for 1 cycle → WAIT_INFO.
- WAIT_INFO: if stop → IDLE; else if sample_valid → ANALYZE.
- ANALYZE, skip case (sample_remaining == 0): increment skip; if sample_last → DRAIN, else → REQ_NEXT.
- ANALYZE, issue case: register addr/id/len.
  - len = min(MAX_BURST, sample_remaining, (4096 − addr[11:0]) >> 2).
  - If outstanding < MAX_OUTSTANDING → SEND; otherwise stay in ANALYZE.
- SEND: dma_req_valid = 1, with address/ID/length stable until dma_req_ready. On accept: outstanding++ and update last_request_id.
  - If sample_last → DRAIN, else → REQ_NEXT.
  - stop while valid & ~ready → IDLE, dropping valid.
- DRAIN: wait for outstanding == 0. If no request was issued in the pass → IDLE with all_samples_invalid = 1 for that cycle; else → WAIT_ALL_DATA.
- WAIT_ALL_DATA: all_samples_received → REQ_NEXT (new pass) and clear the pass-issued flag; stop → IDLE.
- stop from any non-IDLE state → IDLE next cycle.
  - Outstanding counter keeps tracking dma_req_done and is not cleared.
  - start is re-honoured only when outstanding == 0.
- Outstanding counter is $clog2(MAX_OUTSTANDING+1) bits.
  - Simultaneous accept and done: net unchanged.
  - done while counter is 0: ignored; counter saturates at 0.

## Timing
- Reset values: all outputs 0; last_request_id 0; FSM in IDLE; counters 0; pass-issued flag 0.
- ANALYZE → dma_req_valid: 1 cycle. Minimum request-to-request spacing (ready tied high): 4 cycles (SEND, REQ_NEXT, WAIT_INFO, ANALYZE).
- dma_req_* are registered; no combinational path from dma_req_ready to dma_req_valid.
- last_request_sent coincides with the accept cycle, or with the ANALYZE skip cycle of the last entry.

## Configuration
- SAMPLE_DMA_REQ_STATS_EN defined:
  - req_count increments on each accept; skip_count on each skip; both wrap at 2^16.
  - Both clear on the IDLE → ANALYZE transition.
- SAMPLE_DMA_REQ_STATS_EN undefined: req_count and skip_count are constant 0; no counter flops.

## Test plan
- Single entry, addr 0x1000, remaining 200, last, ready = 1 → one request, len 64, last_request_sent pulse, then DRAIN → WAIT_ALL_DATA.
- addr 0x1FF0, remaining 100 → len 4 (4 KB clip). remaining 10 at addr 0x2000 → len 10.
- Three entries all remaining 0 → no dma_req_valid; all_samples_invalid pulse; return to IDLE.
- MAX_OUTSTANDING = 2, five entries, done withheld → exactly 2 accepts, FSM holds in ANALYZE. One done pulse → third request issues.
- Hold ready low for 5 cycles with addr/id/len changing upstream → outputs stable. Assert stop on cycle 3 → valid drops next cycle, FSM in IDLE.
- With macro defined: 4 issued + 2 skipped → req_count = 4, skip_count = 2. Without macro: both read 0.
